// File: rtl/cntl_timeout_timer_if.sv
// Control/status bundle for cntl_timeout_timer.
// master: the controller that arms and steers the timer; slave: the timer.
`timescale 1ns/1ps
interface cntl_timeout_timer_if #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned PRE_W = 4,
  parameter int unsigned EXP_W = 4
);
  logic             en;
  logic             mode;
  logic             pause;
  logic             restart;
  logic [PRE_W-1:0] prescale;
  logic             flag;
  logic             expired;
  logic [EXP_W-1:0] exp_cnt;
  logic [CNT_W-1:0] count;
  logic             mode_q;
  logic             busy;

  modport master (
    output en, mode, pause, restart, prescale,
    input  flag, expired, exp_cnt, count, mode_q, busy
  );

  modport slave (
    input  en, mode, pause, restart, prescale,
    output flag, expired, exp_cnt, count, mode_q, busy
  );
endinterface

// File: rtl/cntl_timeout_timer.sv
// Two-mode timeout timer for the CNTL sideband / link-training FSMs.
// Arms on en, latches mode per arming, pulses flag every LIM+1 ticks and reloads.
// Optional feature macro: CNTL_TIMER_PRESCALE_EN (tick every prescale+1 clocks).
`timescale 1ns/1ps
module cntl_timeout_timer #(
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned SHORT_LIM = 90,
  parameter int unsigned LONG_LIM  = 150,
  parameter int unsigned PRE_W     = 4,
  parameter int unsigned EXP_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cntl_timeout_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic             mode_q_q, mode_q_d;
  logic             flag_q, flag_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_c;
  logic [CNT_W-1:0] lim_c;

  // Terminal count selected by the latched mode.
  assign lim_c = mode_q_q ? CNT_W'(LONG_LIM) : CNT_W'(SHORT_LIM);

`ifdef CNTL_TIMER_PRESCALE_EN
  // Tick when the prescaler reaches the terminal value; >= tolerates a prescale lowered mid-run.
  assign tick_c = (pre_q >= bus.prescale);
`else
  // No prescaler: every running clock is a tick; prescale input is intentionally unused.
  logic unused_prescale;
  assign unused_prescale = ^bus.prescale;
  assign tick_c          = 1'b1;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      exp_cnt_q <= '0;
      mode_q_q  <= 1'b0;
      flag_q    <= 1'b0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
      pre_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      exp_cnt_q <= exp_cnt_d;
      mode_q_q  <= mode_q_d;
      flag_q    <= flag_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
      pre_q     <= pre_d;
    end
  end

  // Next-state: en low always returns to IDLE; pause level chooses RUN/PAUSED once armed.
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:           state_d = S_RUN;
        S_RUN, S_PAUSED:  state_d = bus.pause ? S_PAUSED : S_RUN;
        default:          state_d = S_IDLE;
      endcase
    end
  end

  // Datapath/output next values; priority en=0 > arm > restart > pause > tick.
  always_comb begin
    count_d   = count_q;
    exp_cnt_d = exp_cnt_q;
    mode_q_d  = mode_q_q;
    flag_d    = 1'b0;
    expired_d = expired_q;
    pre_d     = pre_q;
    busy_d    = (state_d != S_IDLE);
    if (!bus.en) begin
      count_d   = '0;
      exp_cnt_d = '0;
      mode_q_d  = 1'b0;
      expired_d = 1'b0;
      pre_d     = '0;
    end else if (state_q == S_IDLE || bus.restart) begin
      // Arm edge or restart: zero everything and re-latch mode.
      count_d   = '0;
      exp_cnt_d = '0;
      mode_q_d  = bus.mode;
      expired_d = 1'b0;
      pre_d     = '0;
    end else if (!bus.pause) begin
`ifdef CNTL_TIMER_PRESCALE_EN
      pre_d = tick_c ? '0 : pre_q + PRE_W'(1);
`endif
      if (tick_c) begin
        if (count_q >= lim_c) begin
          flag_d    = 1'b1;
          count_d   = '0;
          expired_d = 1'b1;
          if (exp_cnt_q != {EXP_W{1'b1}}) begin
            exp_cnt_d = exp_cnt_q + EXP_W'(1);
          end
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.flag    = flag_q;
  assign bus.expired = expired_q;
  assign bus.exp_cnt = exp_cnt_q;
  assign bus.count   = count_q;
  assign bus.mode_q  = mode_q_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_cntl_timeout_timer.sv
// Directed self-checking bench for cntl_timeout_timer (SHORT_LIM=90, LONG_LIM=150).
`timescale 1ns/1ps
module tb_cntl_timeout_timer;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n;

  cntl_timeout_timer_if #(.CNT_W(12), .PRE_W(4), .EXP_W(4)) bus ();

  cntl_timeout_timer #(
    .CNT_W(12), .SHORT_LIM(90), .LONG_LIM(150), .PRE_W(4), .EXP_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  // Advance k rising edges, then settle 1ns past the edge.
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Count edges until flag is seen; returns max when it never rises.
  task automatic wait_flag(input int max, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (!bus.flag && cyc < max);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"},   32'(bus.count),   0);
    chk({tag, "_flag"},    32'(bus.flag),    0);
    chk({tag, "_expired"}, 32'(bus.expired), 0);
    chk({tag, "_exp_cnt"}, 32'(bus.exp_cnt), 0);
    chk({tag, "_mode_q"},  32'(bus.mode_q),  0);
    chk({tag, "_busy"},    32'(bus.busy),    0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    bus.mode = 1'b0;
    bus.pause = 1'b0;
    bus.restart = 1'b0;
    bus.prescale = '0;
    #12;
    chk_all_zero("reset");
    rst = 1'b1;
    step(1);

    // 1: short mode, two expiries.
    bus.en = 1'b1;
    step(1);
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_count_arm", 32'(bus.count), 0);
    wait_flag(400, n);
    chk("t1_first_flag", n, 91);
    chk("t1_expired", 32'(bus.expired), 1);
    chk("t1_exp_cnt1", 32'(bus.exp_cnt), 1);
    chk("t1_count_reload", 32'(bus.count), 0);
    step(1);
    chk("t1_flag_drop", 32'(bus.flag), 0);
    chk("t1_count_after", 32'(bus.count), 1);
    wait_flag(400, n);
    chk("t1_second_flag", n, 90);
    chk("t1_exp_cnt2", 32'(bus.exp_cnt), 2);
    bus.en = 1'b0;
    step(1);
    chk_all_zero("t1_en_off");

    // 2: long mode latched, later mode change ignored.
    bus.mode = 1'b1;
    bus.en = 1'b1;
    step(1);
    chk("t2_mode_q", 32'(bus.mode_q), 1);
    step(9);
    bus.mode = 1'b0;
    wait_flag(400, n);
    chk("t2_flag", n, 142);
    chk("t2_mode_q_kept", 32'(bus.mode_q), 1);
    bus.en = 1'b0;
    step(1);

    // 3: pause at count 40 for 20 clocks.
    bus.en = 1'b1;
    step(1);
    step(40);
    chk("t3_count40", 32'(bus.count), 40);
    bus.pause = 1'b1;
    step(20);
    chk("t3_count_hold", 32'(bus.count), 40);
    chk("t3_busy_paused", 32'(bus.busy), 1);
    chk("t3_no_flag", 32'(bus.flag), 0);
    bus.pause = 1'b0;
    wait_flag(400, n);
    chk("t3_flag", n, 51);
    bus.en = 1'b0;
    step(1);

    // 4: long mode, restart at count 89 after one expiry.
    bus.mode = 1'b1;
    bus.en = 1'b1;
    step(1);
    wait_flag(400, n);
    chk("t4_first_flag", n, 151);
    step(89);
    chk("t4_count89", 32'(bus.count), 89);
    bus.restart = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("t4_rs_count", 32'(bus.count), 0);
    chk("t4_rs_expired", 32'(bus.expired), 0);
    chk("t4_rs_exp_cnt", 32'(bus.exp_cnt), 0);
    wait_flag(400, n);
    chk("t4_next_flag", n, 151);

    // 5: restart on the expiry edge suppresses flag and re-latches mode.
    step(150);
    chk("t5_count150", 32'(bus.count), 150);
    bus.restart = 1'b1;
    bus.mode = 1'b0;
    step(1);
    bus.restart = 1'b0;
    chk("t5_no_flag", 32'(bus.flag), 0);
    chk("t5_count0", 32'(bus.count), 0);
    chk("t5_mode_q0", 32'(bus.mode_q), 0);
    chk("t5_exp_cnt0", 32'(bus.exp_cnt), 0);
    step(10);
    chk("t5_count10", 32'(bus.count), 10);
    bus.en = 1'b0;
    step(1);
    chk_all_zero("t5_en_off");
    // Restart while idle is ignored.
    bus.restart = 1'b1;
    step(1);
    chk("t5_idle_restart_busy", 32'(bus.busy), 0);
    // Arm together with restart: arm wins.
    bus.mode = 1'b1;
    bus.en = 1'b1;
    step(1);
    bus.restart = 1'b0;
    chk("t5_arm_busy", 32'(bus.busy), 1);
    chk("t5_arm_mode_q", 32'(bus.mode_q), 1);
    step(30);
    chk("t5_count30", 32'(bus.count), 30);
    // Async reset mid-cycle.
    rst = 1'b0;
    #1;
    chk_all_zero("t5_async_rst");
    bus.en = 1'b0;
    bus.mode = 1'b0;
    #1;
    rst = 1'b1;
    step(2);
    chk("t5_stay_idle", 32'(bus.busy), 0);

    // 6a: saturation of exp_cnt after 17 expiries.
    bus.en = 1'b1;
    step(1);
    for (int i = 0; i < 17; i++) begin
      wait_flag(200, n);
      chk("t6_period", n, 91);
    end
    chk("t6_exp_sat", 32'(bus.exp_cnt), 15);
    chk("t6_expired", 32'(bus.expired), 1);
    bus.en = 1'b0;
    step(1);

`ifdef CNTL_TIMER_PRESCALE_EN
    // 6b: prescale by 4.
    bus.prescale = 4'd3;
    bus.en = 1'b1;
    step(1);
    wait_flag(800, n);
    chk("t6_prescale_flag", n, 364);
    bus.en = 1'b0;
    bus.prescale = '0;
    step(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
